// File: rtl/lc3_ctrl_fsm.sv
// LC-3 multi-cycle control unit: owns PC, IR and NZP, sequences fetch/decode/execute
// over a req/ack memory port and steers the register file and external ALU.
module lc3_ctrl_fsm #(
    parameter logic [15:0] RESET_PC    = 16'h3000,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_run,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [15:0] i_mem_rdata,
    output logic [2:0]  o_rf_raddr1,
    output logic [2:0]  o_rf_raddr2,
    input  logic [15:0] i_rf_rdata1,
    output logic [1:0]  o_alu_op,
    output logic        o_alu_b_imm,
    output logic [15:0] o_imm,
    input  logic [15:0] i_alu_result,
    output logic        o_rf_we,
    output logic [2:0]  o_rf_waddr,
    output logic [15:0] o_rf_wdata,
    output logic [15:0] o_pc,
    output logic [2:0]  o_nzp,
    output logic        o_halted,
    output logic        o_fault
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED, S_FAULT
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [15:0] TMO_LAST = (MEM_TIMEOUT == 0) ? 16'd0 : 16'(MEM_TIMEOUT - 1);

    state_t      r_state, w_next;
    logic [15:0] r_pc, w_pc_next;
    logic [15:0] r_ir, w_ir_next;
    logic [15:0] r_ld_data, w_ld_next;
    logic [15:0] r_tmo, w_tmo_next;
    logic [2:0]  r_nzp;
    logic        r_run_d;

    logic [3:0]  w_opcode;
    logic [15:0] w_off9;
    logic [15:0] w_mem_ea;
    logic        w_run_rise;
    logic        w_br_taken;
    logic        w_tmo_hit;
    logic [2:0]  w_nzp_new;

    assign w_opcode   = r_ir[15:12];
    assign w_off9     = {{7{r_ir[8]}}, r_ir[8:0]};
    assign w_mem_ea   = r_pc + w_off9;
    assign w_run_rise = i_run & ~r_run_d;
    assign w_br_taken = (r_ir[11] & r_nzp[2]) | (r_ir[10] & r_nzp[1]) | (r_ir[9] & r_nzp[0]);
    assign w_tmo_hit  = (MEM_TIMEOUT != 0) && (r_tmo == TMO_LAST);
    assign w_nzp_new  = {o_rf_wdata[15], o_rf_wdata == 16'h0000,
                         ~o_rf_wdata[15] & (o_rf_wdata != 16'h0000)};

    assign o_rf_raddr2 = r_ir[2:0];
    assign o_rf_waddr  = r_ir[11:9];
    assign o_imm       = {{11{r_ir[4]}}, r_ir[4:0]};
    assign o_pc        = r_pc;
    assign o_nzp       = r_nzp;
    assign o_halted    = (r_state == S_HALTED);
    assign o_fault     = (r_state == S_FAULT);

    always_comb begin
        w_next      = r_state;
        w_pc_next   = r_pc;
        w_ir_next   = r_ir;
        w_ld_next   = r_ld_data;
        w_tmo_next  = r_tmo;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = 16'h0000;
        o_mem_wdata = 16'h0000;
        o_rf_raddr1 = r_ir[8:6];
        o_alu_op    = 2'b00;
        o_alu_b_imm = 1'b0;
        o_rf_we     = 1'b0;
        o_rf_wdata  = 16'h0000;

        case (r_state)
            S_IDLE, S_HALTED: begin
                if (w_run_rise) w_next = S_FETCH;
            end
            S_FETCH: begin
                o_mem_req  = 1'b1;
                o_mem_addr = r_pc;
                if (i_mem_ack) begin
                    w_ir_next = i_mem_rdata;
                    w_pc_next = r_pc + 16'd1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_opcode)
                    OP_ADD, OP_AND, OP_NOT, OP_BR: w_next = S_EXEC;
                    OP_LD, OP_ST:                  w_next = S_MEM;
                    OP_HALT:                       w_next = S_HALTED;
                    default:                       w_next = S_FAULT;
                endcase
            end
            S_EXEC: begin
                w_next = S_FETCH;
                case (w_opcode)
                    OP_ADD, OP_AND: begin
                        o_rf_we     = 1'b1;
                        o_alu_b_imm = r_ir[5];
                        o_alu_op    = (w_opcode == OP_AND) ? 2'b01 : 2'b00;
                        o_rf_wdata  = i_alu_result;
                    end
                    OP_NOT: begin
                        o_rf_we    = 1'b1;
                        o_alu_op   = 2'b10;
                        o_rf_wdata = i_alu_result;
                    end
                    default: begin
                        if (w_br_taken) w_pc_next = w_mem_ea;
                    end
                endcase
            end
            S_MEM: begin
                o_mem_req  = 1'b1;
                o_mem_addr = w_mem_ea;
                if (w_opcode == OP_ST) begin
                    o_mem_we    = 1'b1;
                    o_rf_raddr1 = r_ir[11:9];
                    o_mem_wdata = i_rf_rdata1;
                end
                if (i_mem_ack) begin
                    if (w_opcode == OP_ST) begin
                        w_next = S_FETCH;
                    end else begin
                        w_ld_next = i_mem_rdata;
                        w_next    = S_WB;
                    end
                end
            end
            S_WB: begin
                o_rf_we    = 1'b1;
                o_rf_wdata = r_ld_data;
                w_next     = S_FETCH;
            end
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_FAULT;
        endcase

        // Wait counter only advances while a request is outstanding without ack.
        if (o_mem_req) begin
            if (i_mem_ack) begin
                w_tmo_next = 16'h0000;
            end else if (w_tmo_hit) begin
                w_tmo_next = 16'h0000;
                w_next     = S_FAULT;
            end else begin
                w_tmo_next = r_tmo + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_ir      <= 16'h0000;
            r_ld_data <= 16'h0000;
            r_tmo     <= 16'h0000;
            r_nzp     <= 3'b010;
            r_run_d   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_pc      <= w_pc_next;
            r_ir      <= w_ir_next;
            r_ld_data <= w_ld_next;
            r_tmo     <= w_tmo_next;
            r_run_d   <= i_run;
            if (o_rf_we) r_nzp <= w_nzp_new;
        end
    end

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Scoreboard bench for lc3_ctrl_fsm: models memory, register file and ALU,
// and compares observed memory/register-file transactions against expected queues.
module tb_lc3_ctrl_fsm;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    localparam int EV_RD = 0;
    localparam int EV_WR = 1;
    localparam int EV_RF = 2;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        memReq, memWe, memAck = 1'b0;
    logic [15:0] memAddr, memWdata, memRdata = 16'h0000;
    logic [2:0]  rfRaddr1, rfRaddr2, rfWaddr;
    logic [15:0] rfRdata1, imm, aluResult, rfWdata, pc;
    logic [1:0]  aluOp;
    logic        aluBImm, rfWe, halted, fault;
    logic [2:0]  nzp;
    logic [15:0] aluB;

    logic [15:0] rf [8];
    logic [15:0] rfInit [8];
    logic [15:0] mem [16];
    logic [15:0] memInit [16];

    ev_t expQ[$];
    ev_t monQ[$];
    bit  monEn = 1'b0;
    bit  ackEn = 1'b1;
    int  checks = 0;
    int  errors = 0;

    lc3_ctrl_fsm #(.RESET_PC(16'h3000), .MEM_TIMEOUT(4)) dut (
        .i_clk(clock), .i_rst(rst), .i_run(run),
        .o_mem_req(memReq), .o_mem_we(memWe), .o_mem_addr(memAddr), .o_mem_wdata(memWdata),
        .i_mem_ack(memAck), .i_mem_rdata(memRdata),
        .o_rf_raddr1(rfRaddr1), .o_rf_raddr2(rfRaddr2), .i_rf_rdata1(rfRdata1),
        .o_alu_op(aluOp), .o_alu_b_imm(aluBImm), .o_imm(imm), .i_alu_result(aluResult),
        .o_rf_we(rfWe), .o_rf_waddr(rfWaddr), .o_rf_wdata(rfWdata),
        .o_pc(pc), .o_nzp(nzp), .o_halted(halted), .o_fault(fault)
    );

    initial forever #5 clock = ~clock;

    assign rfRdata1 = rf[rfRaddr1];

    always_comb begin
        aluB      = aluBImm ? imm : rf[rfRaddr2];
        aluResult = 16'h0000;
        case (aluOp)
            2'b00: aluResult = rf[rfRaddr1] + aluB;
            2'b01: aluResult = rf[rfRaddr1] & aluB;
            2'b10: aluResult = ~rf[rfRaddr1];
            default: aluResult = rf[rfRaddr1];
        endcase
    end

    always @(posedge clock) begin
        if (rst) rf <= rfInit;
        else if (rfWe) rf[rfWaddr] <= rfWdata;
    end

    // Monitor first (sees this cycle's outputs), then the 1-cycle-ack memory responder.
    always @(negedge clock) begin
        ev_t o;
        ev_t e;
        monQ.delete();
        if (monEn && memReq && !memAck && ackEn) begin
            o.kind = memWe ? EV_WR : EV_RD;
            o.addr = memAddr;
            o.data = memWe ? memWdata : 16'h0000;
            monQ.push_back(o);
        end
        if (monEn && rfWe) begin
            o.kind = EV_RF;
            o.addr = {13'h0, rfWaddr};
            o.data = rfWdata;
            monQ.push_back(o);
        end
        foreach (monQ[k]) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected: got kind=%0d addr=%h data=%h, expected no event",
                         monQ[k].kind, monQ[k].addr, monQ[k].data);
            end else begin
                e = expQ.pop_front();
                if (e.kind !== monQ[k].kind || e.addr !== monQ[k].addr || e.data !== monQ[k].data) begin
                    errors++;
                    $display("[TB] FAIL sb_event: got kind=%0d addr=%h data=%h, expected kind=%0d addr=%h data=%h",
                             monQ[k].kind, monQ[k].addr, monQ[k].data, e.kind, e.addr, e.data);
                end
            end
        end
        if (rst) begin
            mem      = memInit;
            memAck   = 1'b0;
            memRdata = 16'h0000;
        end else if (memAck) begin
            memAck   = 1'b0;
            memRdata = 16'h0000;
        end else if (memReq && ackEn) begin
            memAck = 1'b1;
            if (memWe) begin
                if (memAddr[15:4] == 12'h300) mem[memAddr[3:0]] = memWdata;
                memRdata = 16'h0000;
            end else begin
                memRdata = (memAddr[15:4] == 12'h300) ? mem[memAddr[3:0]] : 16'h0000;
            end
        end
    end

    task automatic clear_image;
        for (int i = 0; i < 16; i++) memInit[i] = 16'h0000;
        for (int i = 0; i < 8; i++) rfInit[i] = 16'h0000;
    endtask

    task automatic do_reset;
        monEn = 1'b0;
        expQ.delete();
        @(negedge clock);
        rst = 1'b1;
        run = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst = 1'b0;
        monEn = 1'b1;
    endtask

    task automatic push_ev(input int kind, input logic [15:0] addr, input logic [15:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        expQ.push_back(e);
    endtask

    task automatic pulse_run;
        @(negedge clock);
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        #1;
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            #1;
            if (expQ.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) expQ.delete();
    endtask

    task automatic test_reset;
        clear_image();
        do_reset();
        #1;
        checks++;
        if (pc !== 16'h3000) begin errors++; $display("[TB] FAIL reset_pc: got %h, expected 3000", pc); end
        checks++;
        if (nzp !== 3'b010) begin errors++; $display("[TB] FAIL reset_nzp: got %b, expected 010", nzp); end
        checks++;
        if ({memReq, memWe, rfWe, halted, fault} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b, expected 00000", {memReq, memWe, rfWe, halted, fault});
        end
        checks++;
        if ({memAddr, rfWdata, aluOp, aluBImm} !== 35'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got addr=%h wdata=%h op=%b bimm=%b, expected all 0",
                     memAddr, rfWdata, aluOp, aluBImm);
        end
    endtask

    task automatic test_add;
        bit ok;
        clear_image();
        memInit[0] = 16'h1265;
        do_reset();
        push_ev(EV_RD, 16'h3000, 16'h0000);
        push_ev(EV_RF, 16'h0001, 16'h0005);
        pulse_run();
        drain(30, ok);
        monEn = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL add_drain: got pending events, expected none"); end
        checks++;
        if (nzp !== 3'b001) begin errors++; $display("[TB] FAIL add_nzp: got %b, expected 001", nzp); end
        checks++;
        if (pc !== 16'h3001) begin errors++; $display("[TB] FAIL add_pc: got %h, expected 3001", pc); end
    endtask

    task automatic test_ld_br_not_taken;
        bit ok;
        clear_image();
        memInit[0] = 16'h2402;
        memInit[1] = 16'h05FF;
        memInit[3] = 16'h8000;
        do_reset();
        push_ev(EV_RD, 16'h3000, 16'h0000);
        push_ev(EV_RD, 16'h3003, 16'h0000);
        push_ev(EV_RF, 16'h0002, 16'h8000);
        push_ev(EV_RD, 16'h3001, 16'h0000);
        push_ev(EV_RD, 16'h3002, 16'h0000);
        pulse_run();
        drain(40, ok);
        monEn = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL ld_drain: got pending events, expected none"); end
        checks++;
        if (nzp !== 3'b100) begin errors++; $display("[TB] FAIL ld_nzp: got %b, expected 100", nzp); end
        checks++;
        if (pc !== 16'h3003) begin errors++; $display("[TB] FAIL br_n_pc: got %h, expected 3003", pc); end
    endtask

    task automatic test_st;
        bit ok;
        clear_image();
        memInit[0] = 16'h37FF;
        rfInit[3]  = 16'h1234;
        do_reset();
        push_ev(EV_RD, 16'h3000, 16'h0000);
        push_ev(EV_WR, 16'h3000, 16'h1234);
        push_ev(EV_RD, 16'h3001, 16'h0000);
        pulse_run();
        drain(30, ok);
        monEn = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL st_drain: got pending events, expected none"); end
        checks++;
        if (nzp !== 3'b010) begin errors++; $display("[TB] FAIL st_nzp: got %b, expected 010", nzp); end
        checks++;
        if (pc !== 16'h3002) begin errors++; $display("[TB] FAIL st_pc: got %h, expected 3002", pc); end
    endtask

    task automatic test_br_taken;
        bit ok;
        clear_image();
        memInit[0] = 16'h05FF;
        do_reset();
        push_ev(EV_RD, 16'h3000, 16'h0000);
        push_ev(EV_RD, 16'h3000, 16'h0000);
        pulse_run();
        drain(30, ok);
        monEn = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL brz_drain: got pending events, expected none"); end
        checks++;
        if (pc !== 16'h3001) begin errors++; $display("[TB] FAIL brz_pc: got %h, expected 3001", pc); end
    endtask

    task automatic test_halt;
        bit ok;
        int reqs;
        clear_image();
        memInit[0] = 16'hF025;
        do_reset();
        push_ev(EV_RD, 16'h3000, 16'h0000);
        @(negedge clock);
        run = 1'b1;
        drain(20, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL halt_drain: got pending events, expected none"); end
        reqs = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            #1;
            if (memReq) reqs++;
        end
        checks++;
        if (halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_flag: got %b, expected 1", halted); end
        checks++;
        if (reqs !== 0) begin errors++; $display("[TB] FAIL halt_noreq: got %0d reqs, expected 0", reqs); end
        checks++;
        if (pc !== 16'h3001) begin errors++; $display("[TB] FAIL halt_pc: got %h, expected 3001", pc); end
        push_ev(EV_RD, 16'h3001, 16'h0000);
        @(negedge clock);
        run = 1'b0;
        @(negedge clock);
        run = 1'b1;
        drain(20, ok);
        monEn = 1'b0;
        run = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL resume_fetch: got pending events, expected fetch 3001"); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        clear_image();
        memInit[0] = 16'h1265;
        memInit[1] = 16'h5262;
        memInit[2] = 16'h967F;
        memInit[3] = 16'h1401;
        rfInit[0]  = 16'h0007;
        do_reset();
        push_ev(EV_RD, 16'h3000, 16'h0000);
        push_ev(EV_RF, 16'h0001, 16'h0005);
        push_ev(EV_RD, 16'h3001, 16'h0000);
        push_ev(EV_RF, 16'h0001, 16'h0000);
        push_ev(EV_RD, 16'h3002, 16'h0000);
        push_ev(EV_RF, 16'h0003, 16'hFFFF);
        push_ev(EV_RD, 16'h3003, 16'h0000);
        push_ev(EV_RF, 16'h0002, 16'h0007);
        pulse_run();
        drain(60, ok);
        monEn = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL b2b_drain: got pending events, expected none"); end
        checks++;
        if (nzp !== 3'b001) begin errors++; $display("[TB] FAIL b2b_nzp: got %b, expected 001", nzp); end
        checks++;
        if (pc !== 16'h3004) begin errors++; $display("[TB] FAIL b2b_pc: got %h, expected 3004", pc); end
    endtask

    task automatic test_timeout;
        int reqs;
        clear_image();
        ackEn = 1'b0;
        do_reset();
        pulse_run();
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            if (fault) break;
            if (memReq) reqs++;
            @(negedge clock);
            #1;
        end
        checks++;
        if (reqs !== 4) begin errors++; $display("[TB] FAIL tmo_wait: got %0d wait cycles, expected 4", reqs); end
        checks++;
        if ({fault, memReq} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL tmo_fault: got fault=%b req=%b, expected fault=1 req=0", fault, memReq);
        end
        pulse_run();
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if ({fault, memReq} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL fault_sticky: got fault=%b req=%b, expected fault=1 req=0", fault, memReq);
        end
        ackEn = 1'b1;
        monEn = 1'b0;
    endtask

    task automatic test_bad_opcode;
        bit ok;
        clear_image();
        memInit[0] = 16'hD000;
        do_reset();
        push_ev(EV_RD, 16'h3000, 16'h0000);
        pulse_run();
        drain(20, ok);
        monEn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (fault) break;
            @(negedge clock);
            #1;
        end
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL badop_fetch: got pending events, expected none"); end
        checks++;
        if ({fault, memReq} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL badop_fault: got fault=%b req=%b, expected fault=1 req=0", fault, memReq);
        end
    endtask

    task automatic test_reset_in_fetch;
        clear_image();
        memInit[0] = 16'h1265;
        do_reset();
        monEn = 1'b0;
        pulse_run();
        checks++;
        if (memReq !== 1'b1) begin errors++; $display("[TB] FAIL rstf_req_before: got %b, expected 1", memReq); end
        rst = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (memReq !== 1'b0) begin errors++; $display("[TB] FAIL rstf_req: got %b, expected 0", memReq); end
        checks++;
        if (pc !== 16'h3000) begin errors++; $display("[TB] FAIL rstf_pc: got %h, expected 3000", pc); end
        @(negedge clock);
        rst = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if ({pc, nzp, memReq} !== {16'h3000, 3'b010, 1'b0}) begin
            errors++;
            $display("[TB] FAIL rstf_idle: got pc=%h nzp=%b req=%b, expected 3000 010 0", pc, nzp, memReq);
        end
    endtask

    initial begin
        clear_image();
        test_reset();
        test_add();
        test_ld_br_not_taken();
        test_st();
        test_br_taken();
        test_halt();
        test_back_to_back();
        test_timeout();
        test_bad_opcode();
        test_reset_in_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
